// File: rtl/keypad_pkg.sv
// Shared types for the keypad debounce/event stage.
package keypad_pkg;

  localparam int unsigned KEY_COUNT = 16;
  localparam int unsigned KEY_IDX_W = 4;

  typedef logic [KEY_IDX_W-1:0] key_idx_t;
  typedef logic [KEY_COUNT-1:0] key_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2,
    DONE  = 2'd3
  } wait_state_t;

  // Lowest-index priority encoder; returns 0 for an all-zero vector.
  function automatic key_idx_t lowest_set_idx(input key_vec_t vec);
    key_idx_t idx;
    idx = '0;
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (vec[i]) idx = key_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: mismatch counter, stable level flop and registered rise pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw_in,
  output logic stable_out,
  output logic press_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_press;
  logic             w_mismatch;
  logic             w_flip;

  assign w_mismatch = raw_in ^ r_stable;
  assign w_flip     = w_mismatch && (r_cnt == CNT_LAST);

  // Any agreeing cycle restarts the count, so only an unbroken run flips the level.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_press <= w_flip & raw_in;
      if (w_flip) begin
        r_stable <= raw_in;
        r_cnt    <= '0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign stable_out = r_stable;
  assign press_out  = r_press;

endmodule

// File: rtl/keypad_events.sv
// Keypad debounce, press pulses, key query and FX0A wait-for-key handshake.
// Define KEYPAD_WAIT_RELEASE_EN to complete FX0A on release of the captured key.
module keypad_events
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [KEY_COUNT-1:0] keymap_in,
  output logic [KEY_COUNT-1:0] keys_out,
  output logic [KEY_COUNT-1:0] press_out,
  input  logic [KEY_IDX_W-1:0] query_key_in,
  output logic                 query_pressed_out,
  input  logic                 wait_req_in,
  output logic                 wait_ack_out,
  output logic [KEY_IDX_W-1:0] wait_key_out
);

  key_vec_t    w_keys;
  key_vec_t    w_press;
  wait_state_t r_state;
  wait_state_t w_state_nxt;
  key_idx_t    r_wait_key;
  key_idx_t    w_key_nxt;
  logic        r_ack;
  logic        w_ack_nxt;

  for (genvar g = 0; g < KEY_COUNT; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .raw_in    (keymap_in[g]),
      .stable_out(w_keys[g]),
      .press_out (w_press[g])
    );
  end

  // Only fresh press pulses qualify in ARMED, so keys held on entry are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_wait_key;
    case (r_state)
      IDLE: begin
        if (wait_req_in) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (!wait_req_in) begin
          w_state_nxt = IDLE;
        end else if (|w_press) begin
          w_key_nxt = lowest_set_idx(w_press);
`ifdef KEYPAD_WAIT_RELEASE_EN
          w_state_nxt = HELD;
`else
          w_state_nxt = DONE;
`endif
        end
      end
`ifdef KEYPAD_WAIT_RELEASE_EN
      HELD: begin
        if (!wait_req_in) begin
          w_state_nxt = IDLE;
        end else if (!w_keys[r_wait_key]) begin
          w_state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        if (!wait_req_in) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_ack_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_wait_key <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_key <= w_key_nxt;
      r_ack      <= w_ack_nxt;
    end
  end

  assign keys_out          = w_keys;
  assign press_out         = w_press;
  assign query_pressed_out = w_keys[query_key_in];
  assign wait_ack_out      = r_ack;
  assign wait_key_out      = r_wait_key;

endmodule

// File: tb/tb_keypad_events.sv
// Directed bench for keypad_events with DEBOUNCE_CYCLES=4; follows KEYPAD_WAIT_RELEASE_EN if defined.
module tb_keypad_events;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] keymap_in = '0;
  logic [15:0] keys_out;
  logic [15:0] press_out;
  logic [3:0]  query_key_in = '0;
  logic        query_pressed_out;
  logic        wait_req_in = 1'b0;
  logic        wait_ack_out;
  logic [3:0]  wait_key_out;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_events #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .keymap_in        (keymap_in),
    .keys_out         (keys_out),
    .press_out        (press_out),
    .query_key_in     (query_key_in),
    .query_pressed_out(query_pressed_out),
    .wait_req_in      (wait_req_in),
    .wait_ack_out     (wait_ack_out),
    .wait_key_out     (wait_key_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (keys_out !== 16'h0) begin $display("FAIL reset_keys got=%h want=0000", keys_out); n_fail++; end
    n_checks++; if (press_out !== 16'h0) begin $display("FAIL reset_press got=%h want=0000", press_out); n_fail++; end
    n_checks++; if (wait_ack_out !== 1'b0) begin $display("FAIL reset_ack got=%b want=0", wait_ack_out); n_fail++; end
    n_checks++; if (wait_key_out !== 4'h0) begin $display("FAIL reset_wkey got=%h want=0", wait_key_out); n_fail++; end
    step(2);
    rst_in = 1'b0;
    step(1);
  endtask

  task automatic test_debounce();
    keymap_in = 16'h0010;
    step(3);
    n_checks++; if (keys_out !== 16'h0000) begin $display("FAIL deb_early got=%h want=0000", keys_out); n_fail++; end
    step(1);
    n_checks++; if (keys_out !== 16'h0010) begin $display("FAIL deb_keys got=%h want=0010", keys_out); n_fail++; end
    n_checks++; if (press_out !== 16'h0010) begin $display("FAIL deb_press got=%h want=0010", press_out); n_fail++; end
    step(1);
    n_checks++; if (press_out !== 16'h0000) begin $display("FAIL deb_press_one got=%h want=0000", press_out); n_fail++; end
    // 3-cycle glitch on bit 2
    keymap_in = 16'h0014;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++; if (keys_out !== 16'h0010 || press_out !== 16'h0) begin $display("FAIL glitch_%0d keys=%h press=%h want=0010/0000", i, keys_out, press_out); n_fail++; end
    end
    keymap_in = 16'h0010;
    step(5);
    n_checks++; if (keys_out !== 16'h0010) begin $display("FAIL glitch_after got=%h want=0010", keys_out); n_fail++; end
    keymap_in = 16'h0000;
    step(4);
    n_checks++; if (keys_out !== 16'h0000 || press_out !== 16'h0) begin $display("FAIL deb_release keys=%h press=%h want=0000/0000", keys_out, press_out); n_fail++; end
  endtask

  task automatic test_query();
    keymap_in = 16'h0200;
    step(4);
    n_checks++; if (keys_out !== 16'h0200) begin $display("FAIL query_keys got=%h want=0200", keys_out); n_fail++; end
    query_key_in = 4'd9;
    #1;
    n_checks++; if (query_pressed_out !== 1'b1) begin $display("FAIL query_9 got=%b want=1", query_pressed_out); n_fail++; end
    query_key_in = 4'd8;
    #1;
    n_checks++; if (query_pressed_out !== 1'b0) begin $display("FAIL query_8 got=%b want=0", query_pressed_out); n_fail++; end
    keymap_in = 16'h0000;
    step(4);
  endtask

  task automatic test_wait_held_key();
    keymap_in = 16'h0020;
    step(4);
    wait_req_in = 1'b1;
    step(6);
    n_checks++; if (wait_ack_out !== 1'b0) begin $display("FAIL held_noack got=%b want=0", wait_ack_out); n_fail++; end
    keymap_in = 16'h0000;
    step(4);
    n_checks++; if (wait_ack_out !== 1'b0 || keys_out !== 16'h0) begin $display("FAIL held_release ack=%b keys=%h want=0/0000", wait_ack_out, keys_out); n_fail++; end
    keymap_in = 16'h0420;
    step(4);
    n_checks++; if (press_out !== 16'h0420 || wait_ack_out !== 1'b0) begin $display("FAIL held_press press=%h ack=%b want=0420/0", press_out, wait_ack_out); n_fail++; end
    step(1);
    n_checks++; if (wait_key_out !== 4'h5) begin $display("FAIL held_wkey got=%h want=5", wait_key_out); n_fail++; end
`ifdef KEYPAD_WAIT_RELEASE_EN
    n_checks++; if (wait_ack_out !== 1'b0) begin $display("FAIL held_ack_pre got=%b want=0", wait_ack_out); n_fail++; end
    keymap_in = 16'h0000;
    step(4);
    n_checks++; if (wait_ack_out !== 1'b0) begin $display("FAIL held_ack_fall got=%b want=0", wait_ack_out); n_fail++; end
    step(1);
`else
    keymap_in = 16'h0000;
`endif
    n_checks++; if (wait_ack_out !== 1'b1) begin $display("FAIL held_ack got=%b want=1", wait_ack_out); n_fail++; end
    wait_req_in = 1'b0;
    step(1);
    n_checks++; if (wait_ack_out !== 1'b0) begin $display("FAIL held_ack_drop got=%b want=0", wait_ack_out); n_fail++; end
    keymap_in = 16'h0000;
    step(5);
  endtask

`ifndef KEYPAD_WAIT_RELEASE_EN
  task automatic test_wait_press();
    wait_req_in = 1'b1;
    step(1);
    keymap_in = 16'h1000;
    step(4);
    n_checks++; if (press_out !== 16'h1000 || wait_ack_out !== 1'b0) begin $display("FAIL wp_press press=%h ack=%b want=1000/0", press_out, wait_ack_out); n_fail++; end
    step(1);
    n_checks++; if (wait_ack_out !== 1'b1 || wait_key_out !== 4'hC) begin $display("FAIL wp_ack ack=%b key=%h want=1/c", wait_ack_out, wait_key_out); n_fail++; end
    step(2);
    n_checks++; if (wait_ack_out !== 1'b1) begin $display("FAIL wp_hold got=%b want=1", wait_ack_out); n_fail++; end
    wait_req_in = 1'b0;
    step(1);
    n_checks++; if (wait_ack_out !== 1'b0 || wait_key_out !== 4'hC) begin $display("FAIL wp_drop ack=%b key=%h want=0/c", wait_ack_out, wait_key_out); n_fail++; end
    keymap_in = 16'h0000;
    step(5);
  endtask
`else
  task automatic test_wait_release();
    wait_req_in = 1'b1;
    step(1);
    keymap_in = 16'h0008;
    step(4);
    n_checks++; if (press_out !== 16'h0008) begin $display("FAIL wr_press got=%h want=0008", press_out); n_fail++; end
    step(1);
    n_checks++; if (wait_ack_out !== 1'b0 || wait_key_out !== 4'h3) begin $display("FAIL wr_held ack=%b key=%h want=0/3", wait_ack_out, wait_key_out); n_fail++; end
    keymap_in = 16'h0088;
    step(5);
    n_checks++; if (wait_ack_out !== 1'b0 || wait_key_out !== 4'h3) begin $display("FAIL wr_key7 ack=%b key=%h want=0/3", wait_ack_out, wait_key_out); n_fail++; end
    keymap_in = 16'h0080;
    step(4);
    n_checks++; if (keys_out !== 16'h0080 || wait_ack_out !== 1'b0) begin $display("FAIL wr_fall keys=%h ack=%b want=0080/0", keys_out, wait_ack_out); n_fail++; end
    step(1);
    n_checks++; if (wait_ack_out !== 1'b1 || wait_key_out !== 4'h3) begin $display("FAIL wr_ack ack=%b key=%h want=1/3", wait_ack_out, wait_key_out); n_fail++; end
    wait_req_in = 1'b0;
    step(1);
    n_checks++; if (wait_ack_out !== 1'b0) begin $display("FAIL wr_drop got=%b want=0", wait_ack_out); n_fail++; end
    keymap_in = 16'h0000;
    step(5);
  endtask
`endif

  task automatic test_reset_mid();
    wait_req_in = 1'b1;
    step(1);
    keymap_in = 16'h0002;
    step(5);
    n_checks++; if (wait_key_out !== 4'h1) begin $display("FAIL rm_capture got=%h want=1", wait_key_out); n_fail++; end
    #2;
    rst_in = 1'b1;
    wait_req_in = 1'b0;
    keymap_in = 16'h0000;
    #1;
    n_checks++; if (keys_out !== 16'h0 || press_out !== 16'h0 || wait_ack_out !== 1'b0 || wait_key_out !== 4'h0) begin $display("FAIL rm_async keys=%h press=%h ack=%b key=%h want=0", keys_out, press_out, wait_ack_out, wait_key_out); n_fail++; end
    step(2);
    rst_in = 1'b0;
    step(2);
    n_checks++; if (wait_ack_out !== 1'b0 || keys_out !== 16'h0) begin $display("FAIL rm_idle ack=%b keys=%h want=0/0000", wait_ack_out, keys_out); n_fail++; end
    // fresh request with two simultaneous presses: lowest index wins
    wait_req_in = 1'b1;
    step(1);
    keymap_in = 16'h4100;
    step(5);
    n_checks++; if (wait_key_out !== 4'h8) begin $display("FAIL rm_fresh_key got=%h want=8", wait_key_out); n_fail++; end
`ifdef KEYPAD_WAIT_RELEASE_EN
    keymap_in = 16'h4000;
    step(5);
`endif
    n_checks++; if (wait_ack_out !== 1'b1) begin $display("FAIL rm_fresh_ack got=%b want=1", wait_ack_out); n_fail++; end
    wait_req_in = 1'b0;
    keymap_in = 16'h0000;
    step(1);
    n_checks++; if (wait_ack_out !== 1'b0) begin $display("FAIL rm_fresh_drop got=%b want=0", wait_ack_out); n_fail++; end
    step(5);
  endtask

  task automatic test_abort();
    wait_req_in = 1'b1;
    step(1);
    keymap_in = 16'h0001;
    step(3);
    // drop request in the same cycle the press pulse is visible
    wait_req_in = 1'b0;
    step(1);
    n_checks++; if (press_out !== 16'h0001) begin $display("FAIL ab_press got=%h want=0001", press_out); n_fail++; end
    step(1);
    n_checks++; if (wait_ack_out !== 1'b0 || wait_key_out !== 4'h8) begin $display("FAIL ab_noack ack=%b key=%h want=0/8", wait_ack_out, wait_key_out); n_fail++; end
    keymap_in = 16'h0000;
    step(5);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_query();
    test_wait_held_key();
`ifndef KEYPAD_WAIT_RELEASE_EN
    test_wait_press();
`else
    test_wait_release();
`endif
    test_reset_mid();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
